cnn_layer_sequencer: RTL and testbench

Top-level inference controller for the SimpleCNN datapath. It sequences one full image pass across two shared engines over valid/ready handshakes:
- the convolution/pool engine, one window op per 5x5 kernel position;
- the fully connected MAC engine, one op per feature/weight pair.

It also collects the 10 class scores and reports the argmax as the predicted digit. It sits between the image/weight store and the compute engines and owns the start/done handshake toward the testbench or host.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/cnn_nest_counter.sv | 60 ++++++
 rtl/cnn_layer_sequencer.sv | 158 +++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, derived index widths and sequencer state type for the SimpleCNN controller.
package cnn_pkg;
  localparam int IMG_W   = 28;
  localparam int K_W     = 5;
  localparam int N_KERN  = 8;
  localparam int POOL    = 2;
  localparam int CONV_W  = IMG_W - K_W + 1;
  localparam int FC_IN   = N_KERN * (CONV_W / POOL) * (CONV_W / POOL);
  localparam int N_CLASS = 10;

  localparam int KERN_W = $clog2(N_KERN);
  localparam int ROW_W  = $clog2(CONV_W);
  localparam int CLS_W  = $clog2(N_CLASS);
  localparam int IDX_W  = $clog2(FC_IN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_CONV_WAIT,
    S_FC,
    S_RES_WAIT,
    S_DONE
  } seq_state_t;
endpackage

// File: rtl/cnn_nest_counter.sv
// Two- or three-level wrapping index counter; digit 0 is outermost, the innermost digit moves fastest.
module cnn_nest_counter #(
  parameter int LEVELS = 3,
  parameter int N0 = 2,
  parameter int N1 = 2,
  parameter int N2 = 2,
  parameter int W0 = 1,
  parameter int W1 = 1,
  parameter int W2 = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          clr_i,
  input  logic                                          adv_i,
  output logic [W0+W1+((LEVELS == 3) ? W2 : 0)-1:0]     idx_o,
  output logic                                          last_o
);
  logic [W0-1:0] d0_q;
  logic [W1-1:0] d1_q;
  logic          l0, l1, lo_last, adv1;

  assign l0 = (d0_q == W0'(N0 - 1));
  assign l1 = (d1_q == W1'(N1 - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d0_q <= '0;
      d1_q <= '0;
    end else if (clr_i) begin
      d0_q <= '0;
      d1_q <= '0;
    end else if (adv1) begin
      d1_q <= l1 ? '0 : d1_q + 1'b1;
      if (l1) d0_q <= l0 ? '0 : d0_q + 1'b1;
    end
  end

  if (LEVELS == 3) begin : g_three
    logic [W2-1:0] d2_q;
    logic          l2;

    assign l2 = (d2_q == W2'(N2 - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     d2_q <= '0;
      else if (clr_i)  d2_q <= '0;
      else if (adv_i)  d2_q <= l2 ? '0 : d2_q + 1'b1;
    end

    assign adv1    = adv_i && l2;
    assign lo_last = l2;
    assign idx_o   = {d0_q, d1_q, d2_q};
  end else begin : g_two
    assign adv1    = adv_i;
    assign lo_last = 1'b1;
    assign idx_o   = {d0_q, d1_q};
  end

  assign last_o = l0 && l1 && lo_last;
endmodule

// File: rtl/cnn_layer_sequencer.sv
// Image-pass controller: conv ops, FC ops, class-score argmax. Define CNN_SEQ_PERF_EN for stall/busy counters.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     conv_valid,
  input  logic                     conv_ready,
  output logic [KERN_W-1:0]        conv_kern,
  output logic [ROW_W-1:0]         conv_row,
  output logic [ROW_W-1:0]         conv_col,
  input  logic                     conv_idle,
  output logic                     fc_valid,
  input  logic                     fc_ready,
  output logic [CLS_W-1:0]         fc_class,
  output logic [IDX_W-1:0]         fc_idx,
  output logic                     fc_first,
  output logic                     fc_last,
  input  logic                     res_valid,
  input  logic signed [DATA_W-1:0] res_data,
  output logic [CLS_W-1:0]         pred_class,
  output logic signed [DATA_W-1:0] pred_score
`ifdef CNN_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_total
`endif
);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  seq_state_t                  state_q, state_d;
  logic [CLS_W-1:0]            res_cnt_q, res_cnt_d;
  logic signed [DATA_W-1:0]    best_q, best_d, pred_score_q;
  logic [CLS_W-1:0]            best_cls_q, best_cls_d, pred_class_q;
  logic [KERN_W+2*ROW_W-1:0]   conv_idx;
  logic [CLS_W+IDX_W-1:0]      fc_cnt;
  logic                        conv_all_last, fc_all_last;
  logic                        start_acc, conv_hs, fc_hs, res_take;

  assign start_acc  = (state_q == S_IDLE) && start;
  assign conv_valid = (state_q == S_CONV);
  assign fc_valid   = (state_q == S_FC);
  assign conv_hs    = conv_valid && conv_ready;
  assign fc_hs      = fc_valid && fc_ready;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign res_take   = res_valid && ((state_q == S_FC) || (state_q == S_RES_WAIT))
                      && (res_cnt_q != CLS_W'(N_CLASS));

  cnn_nest_counter #(
    .LEVELS(3), .N0(N_KERN), .N1(CONV_W), .N2(CONV_W),
    .W0(KERN_W), .W1(ROW_W), .W2(ROW_W)
  ) u_conv_cnt (
    .clk_i(clk), .rst_ni(rst), .clr_i(start_acc), .adv_i(conv_hs),
    .idx_o(conv_idx), .last_o(conv_all_last)
  );

  cnn_nest_counter #(
    .LEVELS(2), .N0(N_CLASS), .N1(FC_IN), .N2(1),
    .W0(CLS_W), .W1(IDX_W), .W2(1)
  ) u_fc_cnt (
    .clk_i(clk), .rst_ni(rst), .clr_i(start_acc), .adv_i(fc_hs),
    .idx_o(fc_cnt), .last_o(fc_all_last)
  );

  assign conv_kern = conv_idx[2*ROW_W +: KERN_W];
  assign conv_row  = conv_idx[ROW_W +: ROW_W];
  assign conv_col  = conv_idx[0 +: ROW_W];
  assign fc_class  = fc_cnt[IDX_W +: CLS_W];
  assign fc_idx    = fc_cnt[0 +: IDX_W];
  assign fc_first  = fc_valid && (fc_idx == '0);
  assign fc_last   = fc_valid && (fc_idx == IDX_W'(FC_IN - 1));

  // Strictly-greater update keeps the lowest class on ties.
  always_comb begin
    res_cnt_d  = res_cnt_q;
    best_d     = best_q;
    best_cls_d = best_cls_q;
    if (start_acc) begin
      res_cnt_d  = '0;
      best_d     = MOST_NEG;
      best_cls_d = '0;
    end else if (res_take) begin
      res_cnt_d = res_cnt_q + 1'b1;
      if (res_data > best_q) begin
        best_d     = res_data;
        best_cls_d = res_cnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_CONV;
      S_CONV:      if (conv_hs && conv_all_last) state_d = S_CONV_WAIT;
      S_CONV_WAIT: if (conv_idle) state_d = S_FC;
      S_FC:        if (fc_hs && fc_all_last) state_d = S_RES_WAIT;
      S_RES_WAIT:  if (res_cnt_d == CLS_W'(N_CLASS)) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      res_cnt_q    <= '0;
      pred_class_q <= '0;
      pred_score_q <= '0;
    end else begin
      state_q   <= state_d;
      res_cnt_q <= res_cnt_d;
      if ((state_q == S_RES_WAIT) && (state_d == S_DONE)) begin
        pred_class_q <= best_cls_d;
        pred_score_q <= best_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    best_q     <= best_d;
    best_cls_q <= best_cls_d;
  end

  assign pred_class = pred_class_q;
  assign pred_score = pred_score_q;

`ifdef CNN_SEQ_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_stall_q, perf_total_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_total_q <= '0;
    end else if (start_acc) begin
      perf_stall_q <= '0;
      perf_total_q <= '0;
    end else begin
      if (busy) perf_total_q <= sat_inc(perf_total_q);
      if ((conv_valid && !conv_ready) || (fc_valid && !fc_ready))
        perf_stall_q <= sat_inc(perf_stall_q);
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_total = perf_total_q;
`endif
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: expected op streams and predictions queued at start, checked by a monitor.
module tb_cnn_layer_sequencer;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               busy, done;
  logic               conv_valid, fc_valid;
  logic               conv_ready = 1'b1, fc_ready = 1'b1, conv_idle = 1'b1;
  logic [2:0]         conv_kern;
  logic [4:0]         conv_row, conv_col;
  logic [3:0]         fc_class;
  logic [10:0]        fc_idx;
  logic               fc_first, fc_last;
  logic               res_valid = 1'b0;
  logic signed [31:0] res_data = '0;
  logic [3:0]         pred_class;
  logic signed [31:0] pred_score;

  cnn_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .conv_valid(conv_valid), .conv_ready(conv_ready),
    .conv_kern(conv_kern), .conv_row(conv_row), .conv_col(conv_col),
    .conv_idle(conv_idle), .fc_valid(fc_valid), .fc_ready(fc_ready),
    .fc_class(fc_class), .fc_idx(fc_idx), .fc_first(fc_first), .fc_last(fc_last),
    .res_valid(res_valid), .res_data(res_data),
    .pred_class(pred_class), .pred_score(pred_score)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int exp_conv_q[$], exp_fc_q[$], exp_cls_q[$], exp_score_q[$], res_pend_q[$];
  int cur_scores[10];
  int cnt_conv, cnt_fc, done_cnt, res_seen, res10_cyc, cyc = 0;
  bit mon_en = 0, bp_en = 0, hit_c4 = 0;
  bit conv_hold = 0, fc_hold = 0;
  logic [12:0] conv_prev;
  logic [16:0] fc_prev;

  int scA[10] = '{3, -20, 15, 8, 0, -7, 22, 100, 99, -100};
  int scT[10] = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
  int scN[10] = '{-50, -3, -7, -1000, -2, -9, -4, -8, -6, -1};

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event with no expected entry (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // Stall/ready driver and FC engine model: one class sum per accepted fc_last.
  always @(posedge clk) begin
    #1;
    conv_ready = bp_en ? ($urandom_range(7) != 0) : 1'b1;
    fc_ready   = bp_en ? ($urandom_range(7) != 0) : 1'b1;
    if (rst && res_pend_q.size() > 0) begin
      res_valid = 1'b1;
      res_data  = cur_scores[res_pend_q.pop_front()];
    end else begin
      res_valid = 1'b0;
      res_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      conv_hold = 0;
      fc_hold   = 0;
    end else begin
      if (conv_hold)
        check("conv_hold", {conv_valid, conv_kern, conv_row, conv_col}, {1'b1, conv_prev});
      if (fc_hold)
        check("fc_hold", {fc_valid, fc_class, fc_idx, fc_first, fc_last}, {1'b1, fc_prev});
      check("valid_excl", conv_valid && fc_valid, 0);
      if (conv_valid && conv_ready) begin
        cnt_conv++;
        if (exp_conv_q.size() == 0) unexpected("conv_extra");
        else check("conv_seq", {conv_kern, conv_row, conv_col}, exp_conv_q.pop_front());
      end
      if (fc_valid && fc_ready) begin
        cnt_fc++;
        if (fc_class == 4'd4 && fc_idx == 11'd300) hit_c4 = 1;
        if (fc_last) res_pend_q.push_back(int'(fc_class));
        if (exp_fc_q.size() == 0) unexpected("fc_extra");
        else check("fc_seq", {fc_class, fc_idx, fc_first, fc_last}, exp_fc_q.pop_front());
      end
      if (res_valid && busy) begin
        res_seen++;
        if (res_seen == 10) res10_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_lat", cyc, res10_cyc + 1);
        if (exp_cls_q.size() == 0) unexpected("done_extra");
        else begin
          check("pred_class", pred_class, exp_cls_q.pop_front());
          check("pred_score", pred_score, exp_score_q.pop_front());
        end
      end
      conv_hold = conv_valid && !conv_ready;
      fc_hold   = fc_valid && !fc_ready;
      conv_prev = {conv_kern, conv_row, conv_col};
      fc_prev   = {fc_class, fc_idx, fc_first, fc_last};
    end
  end

  task automatic issue(input int sc[10], input int ecls, input int escore);
    for (int k = 0; k < 8; k++)
      for (int r = 0; r < 24; r++)
        for (int c = 0; c < 24; c++)
          exp_conv_q.push_back((k << 10) | (r << 5) | c);
    for (int c = 0; c < 10; c++)
      for (int i = 0; i < 1152; i++)
        exp_fc_q.push_back((c << 13) | (i << 2) | (int'(i == 0) << 1) | int'(i == 1151));
    exp_cls_q.push_back(ecls);
    exp_score_q.push_back(escore);
    for (int i = 0; i < 10; i++) cur_scores[i] = sc[i];
    cnt_conv = 0; cnt_fc = 0; done_cnt = 0; res_seen = 0; res10_cyc = -10;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_t1", busy, 1);
    check("first_op", {conv_valid, conv_kern, conv_row, conv_col}, 14'h2000);
  endtask

  task automatic finish_pass(input int idle_delay);
    if (idle_delay > 0) begin
      for (int i = 0; i < 20000 && cnt_conv < 4608; i++) @(negedge clk);
      check("conv_reach", cnt_conv, 4608);
      for (int i = 0; i < idle_delay; i++) begin
        @(negedge clk);
        check("fc_wait_idle", fc_valid, 0);
      end
      @(posedge clk); #1 conv_idle = 1'b1;
      @(negedge clk);
      check("fc_before_idle", fc_valid, 0);
      @(negedge clk);
      check("fc_after_idle", fc_valid, 1);
    end
    for (int i = 0; i < 40000 && done_cnt == 0; i++) @(negedge clk);
    check("done_seen", done_cnt, 1);
    repeat (3) @(negedge clk);
    check("conv_count", cnt_conv, 4608);
    check("fc_count", cnt_fc, 11520);
    check("done_count", done_cnt, 1);
    check("busy_after", busy, 0);
    check("sb_empty", exp_conv_q.size() + exp_fc_q.size() + exp_cls_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, done, conv_valid, fc_valid, fc_first, fc_last}, 0);
    check({tag, "_conv_idx"}, {conv_kern, conv_row, conv_col}, 0);
    check({tag, "_fc_idx"}, {fc_class, fc_idx}, 0);
    check({tag, "_pred_class"}, pred_class, 0);
    check({tag, "_pred_score"}, pred_score, 0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #3 rst = 1'b1;
    mon_en = 1;

    // Ready high; a stray start mid-pass must be ignored.
    issue(scA, 7, 100);
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_pass(0);
    check("pred_hold", pred_class, 7);

    // Random backpressure on both engines.
    bp_en = 1;
    issue(scA, 7, 100);
    finish_pass(0);
    bp_en = 0;

    // All-equal scores with conv_idle held low after the last conv op.
    conv_idle = 1'b0;
    issue(scT, 0, -5);
    finish_pass(50);

    // Reset in the middle of FC, then a fresh pass.
    hit_c4 = 0;
    issue(scA, 7, 100);
    for (int i = 0; i < 20000 && !hit_c4; i++) @(negedge clk);
    check("c4_reach", hit_c4, 1);
    #2 rst = 1'b0;
    mon_en = 0;
    res_pend_q.delete();
    exp_conv_q.delete();
    exp_fc_q.delete();
    exp_cls_q.delete();
    exp_score_q.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_done", {done, busy}, 0);
    end
    mon_en = 1;
    issue(scN, 9, -1);
    finish_pass(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
